// File: rtl/dec_arbiter.sv
// Round-robin sequencer for the shared 14-bit subtract-one datapath.
// Grants one of two requesters, then applies n decrements, one per cycle.
module dec_arbiter #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [CNT_W-1:0] n0,
  input  logic [WIDTH-1:0] a1,
  input  logic [CNT_W-1:0] n1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] result,
  output logic             underflow,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [WIDTH-1:0] ACC_ONE = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             uf_q, uf_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             underflow_q, underflow_d;

  logic             win_any;
  logic             win_k;

  // On a tie the favoured requester (prio) wins; otherwise the lone requester.
  always_comb begin
    win_any = |req;
    win_k   = 1'b0;
    if (req == 2'b11) begin
      win_k = prio_q;
    end else if (req == 2'b10) begin
      win_k = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    uf_d        = uf_q;
    prio_d      = prio_q;
    result_d    = result_q;
    underflow_d = underflow_q;
    gnt         = '0;
    done        = '0;
    case (state_q)
      S_IDLE: begin
        if (win_any) begin
          gnt[win_k] = 1'b1;
          acc_d      = win_k ? a1 : a0;
          cnt_d      = win_k ? n1 : n0;
          owner_d    = win_k;
          uf_d       = 1'b0;
          prio_d     = ~win_k;
          if (cnt_d == '0) begin
            state_d     = S_DONE;
            result_d    = acc_d;
            underflow_d = 1'b0;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d = acc_q - ACC_ONE;
        uf_d  = uf_q | (acc_q == '0);
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d     = S_DONE;
          result_d    = acc_d;
          underflow_d = uf_d;
        end
      end
      S_DONE: begin
        done[owner_q] = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      uf_q        <= 1'b0;
      prio_q      <= 1'b0;
      result_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      uf_q        <= uf_d;
      prio_q      <= prio_d;
      result_q    <= result_d;
      underflow_q <= underflow_d;
    end
  end

  assign result    = result_q;
  assign underflow = underflow_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dec_arbiter.sv
// Directed bench for dec_arbiter: latency, wrap, zero count, round-robin,
// mid-run reset and ignore-while-busy.
module tb_dec_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [13:0] a0, a1;
  logic [3:0]  n0, n1;
  logic [1:0]  gnt, done;
  logic [13:0] result;
  logic        underflow, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec_arbiter #(.WIDTH(14), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req(req),
    .a0(a0), .n0(n0), .a1(a1), .n1(n1),
    .gnt(gnt), .done(done), .result(result),
    .underflow(underflow), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single uncontended request: check grant cycle, quiet RUN cycles, done at T+n+1.
  task automatic run_req(input string tag, input int k, input logic [13:0] a,
                         input logic [3:0] n, input logic [13:0] exp_res,
                         input logic exp_uf);
    logic [1:0] onehot;
    onehot = (k == 1) ? 2'b10 : 2'b01;
    if (k == 1) begin a1 = a; n1 = n; end else begin a0 = a; n0 = n; end
    req = onehot;
    #1;
    check({tag, ".gnt"}, 32'(gnt), 32'(onehot));
    check({tag, ".busyT"}, 32'(busy), 32'd0);
    step();
    req = 2'b00;
    #1;
    for (int i = 1; i <= int'(n); i++) begin
      check({tag, ".nodone"}, 32'(done), 32'd0);
      check({tag, ".busy"}, 32'(busy), 32'd1);
      step();
      #1;
    end
    check({tag, ".done"}, 32'(done), 32'(onehot));
    check({tag, ".result"}, 32'(result), 32'(exp_res));
    check({tag, ".uf"}, 32'(underflow), 32'(exp_uf));
    check({tag, ".busyD"}, 32'(busy), 32'd1);
    step();
    #1;
    check({tag, ".doneoff"}, 32'(done), 32'd0);
    check({tag, ".busyoff"}, 32'(busy), 32'd0);
    check({tag, ".hold"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    reset = 1'b1; req = '0; a0 = '0; a1 = '0; n0 = '0; n1 = '0;
    step(); step();
    #1;
    check("rst.gnt", 32'(gnt), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.uf", 32'(underflow), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    reset = 1'b0;

    run_req("single", 0, 14'h0010, 4'd3, 14'h000D, 1'b0);
    run_req("wrap",   1, 14'h0001, 4'd3, 14'h3FFE, 1'b1);
    run_req("zero",   0, 14'h2A5C, 4'd0, 14'h2A5C, 1'b0);

    // Reset in the middle of a long run: no done, outputs cleared, prio back to 0.
    a0 = 14'h0100; n0 = 4'd15; req = 2'b01;
    #1;
    check("mid.gnt", 32'(gnt), 32'd1);
    step();
    req = 2'b00;
    for (int i = 1; i < 5; i++) begin
      #1;
      check("mid.nodone", 32'(done), 32'd0);
      step();
    end
    #1;
    check("mid.T5busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("mid.gnt0", 32'(gnt), 32'd0);
    check("mid.done0", 32'(done), 32'd0);
    check("mid.result0", 32'(result), 32'd0);
    check("mid.uf0", 32'(underflow), 32'd0);
    check("mid.busy0", 32'(busy), 32'd0);

    // Contention: both held high, n = 1 each -> grants 0,1,0,1 every 3 cycles.
    a0 = 14'h0005; n0 = 4'd1; a1 = 14'h0000; n1 = 4'd1; req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      logic [1:0] exp_g;
      exp_g = (g % 2 == 1) ? 2'b10 : 2'b01;
      #1;
      check("rr.gnt", 32'(gnt), 32'(exp_g));
      step();
      #1;
      check("rr.gntoff", 32'(gnt), 32'd0);
      step();
      #1;
      check("rr.done", 32'(done), 32'(exp_g));
      check("rr.result", 32'(result), (g % 2 == 1) ? 32'h3FFF : 32'h0004);
      check("rr.uf", 32'(underflow), (g % 2 == 1) ? 32'd1 : 32'd0);
      if (g == 3) req = 2'b00;
      step();
    end

    // Max count with requester 1 arriving mid-run; it must wait until T+17.
    a0 = 14'h000A; n0 = 4'd15; req = 2'b01;
    #1;
    check("max.gnt", 32'(gnt), 32'd1);
    step();
    req = 2'b00;
    step(); step();
    a1 = 14'h0005; n1 = 4'd0; req = 2'b10;
    for (int i = 3; i <= 15; i++) begin
      #1;
      check("max.busygnt", 32'(gnt), 32'd0);
      check("max.nodone", 32'(done), 32'd0);
      step();
    end
    #1;
    check("max.done", 32'(done), 32'd1);
    check("max.result", 32'(result), 32'h3FFB);
    check("max.uf", 32'(underflow), 32'd1);
    check("max.gntD", 32'(gnt), 32'd0);
    step();
    #1;
    check("max.gnt1", 32'(gnt), 32'd2);
    step();
    req = 2'b00;
    #1;
    check("max.done1", 32'(done), 32'd2);
    check("max.result1", 32'(result), 32'h0005);
    check("max.uf1", 32'(underflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/dec_arbiter.md
# dec_arbiter

Sequencer and arbiter for the shared 14-bit subtract-one datapath in the stack machine. Two requesters (port 0: stack-pointer unit, port 1: loop/branch counter unit) request a multi-step decrement of a 14-bit operand. The block grants one requester at a time with round-robin priority and drives the single decrement unit once per cycle for the requested step count. It returns the result with a one-cycle done pulse and a wrap (underflow) flag.

## Interface

Parameters:
- WIDTH, 14: operand/result width; fixed at 14 to match the decrement unit.
- CNT_W, 4: step-count width; max 15 steps per request.

Ports (clock and reset first):
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  2  request level per requester; bit k for requester k.
- a0  input  WIDTH  operand for requester 0.
- n0  input  CNT_W  step count for requester 0.
- a1  input  WIDTH  operand for requester 1.
- n1  input  CNT_W  step count for requester 1.
- gnt  output  2  one-hot grant; combinational, asserted only in IDLE.
- done  output  2  one-hot, one-cycle completion pulse to the granted requester.
- result  output  WIDTH  final value, registered, held until the next done.
- underflow  output  1  registered; valid with done, held with result.
- busy  output  1  high in RUN and DONE.

## Operation

- States: IDLE, RUN, DONE. Reset enters IDLE.
- Internal registers:
  - acc[13:0], cnt[CNT_W-1:0], owner (1 bit), uf (1 bit).
  - prio (1 bit): the requester favoured on a tie.
- IDLE, arbitration:
  - If exactly one req bit is high, grant that requester.
  - If both are high, grant requester prio.
  - gnt[k] is high in the same cycle as the granted req.
- IDLE, at the granting edge:
  - acc <= a_k, cnt <= n_k, owner <= k, uf <= 0, prio <= ~k.
  - Next state: RUN if n_k != 0, else DONE.
- RUN, each edge:
  - acc <= decrement(acc), with arithmetic modulo 2^14.
  - uf <= uf | (acc == 14'h0000).
  - cnt <= cnt - 1.
  - When cnt == 1, go to DONE.
- DONE, for one cycle:
  - done[owner] = 1, result = acc, underflow = uf.
  - Next edge returns to IDLE.
- result and underflow are updated only at the edge entering DONE; they hold otherwise.
- Requester contract:
  - Hold req and operands stable until its gnt bit is seen.
  - Deassert req the cycle after gnt; a req still high after done is treated as a new request.
- req changes during RUN or DONE are ignored. No queuing inside the block.
- n = 0: result = operand unchanged, underflow = 0.

## Timing

- Reset values: gnt = 0, done = 0, result = 0, underflow = 0, busy = 0. Also prio = 0, state = IDLE.
- Reset asserted mid-operation (RUN or DONE): abort with no done pulse. All outputs return to reset values the following cycle.
- Latency: grant in cycle T, done in cycle T + n + 1. For n = 0, done is in cycle T + 1.
- Occupancy is n + 2 cycles per request, counting the IDLE grant cycle. The next grant can occur at earliest in cycle T + n + 2.
- Wrap: a step from 14'h0000 yields 14'h3FFF and sets uf; uf is sticky for the remainder of the request.
- Simultaneous requests: round-robin alternation. Two requesters continuously asserting req alternate grants 0, 1, 0, 1… starting with 0 after reset.
- busy is low in the grant cycle itself (IDLE) and high from T + 1 through the done cycle.

## Test plan

- Reset then single request: req = 01, a0 = 14'h0010, n0 = 3 -> gnt = 01 in cycle T; done = 01 at T + 4; result = 14'h000D; underflow = 0.
- Wrap: req = 10, a1 = 14'h0001, n1 = 3 -> done = 10 at T + 4; result = 14'h3FFE; underflow = 1.
- Zero count: req = 01, a0 = 14'h2A5C, n0 = 0 -> done at T + 1; result = 14'h2A5C; underflow = 0; busy high only in cycle T + 1.
- Contention: both req held high, n0 = n1 = 1 -> grants alternate 0, 1, 0, 1, spaced 3 cycles apart; prio toggles accordingly.
- Reset mid-RUN: a0 = 14'h0100, n0 = 15, reset pulsed at T + 5 -> no done pulse; all outputs 0 next cycle; the next contended grant goes to requester 0.
- Max count and ignore-while-busy: a0 = 14'h000A, n0 = 15, req1 raised during RUN -> result = 14'h3FFB with underflow = 1 at T + 16. Requester 1 is granted in cycle T + 17, not earlier.
